ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue_if.sv | 29 ++
 rtl/ifetch_queue.sv | 132 +++++++++++++
 tb/tb_ifetch_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-side bus bundle: cache request/response and decoder valid/ready handshake.
// master = fetch unit, slave = cache/decoder side.
interface ifetch_queue_if #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INST_W   = 32,
    parameter int unsigned IQ_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(IQ_DEPTH) + 1;

    logic [ADDR_W-1:0] next_PC;
    logic              next_inst;
    logic              cache_rdy;
    logic [INST_W-1:0] inst_in;
    logic              if2dec;
    logic              dec_rdy;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] pc_out;
    logic [CNT_W-1:0]  iq_count;

    modport master (
        output next_PC, next_inst, if2dec, inst_out, pc_out, iq_count,
        input  cache_rdy, inst_in, dec_rdy
    );

    modport slave (
        input  next_PC, next_inst, if2dec, inst_out, pc_out, iq_count,
        output cache_rdy, inst_in, dec_rdy
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with an IQ_DEPTH-entry instruction/PC queue and control-flow stall.
// Optional macro IF_JAL_FOLLOW_EN: JAL target computed at accept instead of stalling.
module ifetch_queue #(
    parameter int unsigned     ADDR_W   = 32,
    parameter int unsigned     INST_W   = 32,
    parameter int unsigned     IQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              rdy_in,
    ifetch_queue_if.master    bus,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rob2if,
    input  logic              alu2if_cont,
    input  logic [ADDR_W-1:0] alu2if,
    input  logic              decUpd,
    input  logic [ADDR_W-1:0] dec2if
);
    localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              if_stall_q, if_stall_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_mem_q   [IQ_DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [IQ_DEPTH];
    logic [INST_W-1:0] inst_mem_q [IQ_DEPTH];
    logic [INST_W-1:0] inst_mem_d [IQ_DEPTH];

    logic              req;
    logic              accept;
    logic              pop;
    logic              stall_on_accept;
    logic [ADDR_W-1:0] accept_next_pc;
`ifdef IF_JAL_FOLLOW_EN
    logic [ADDR_W-1:0] jal_imm;
`endif

    always_comb begin
        req    = !if_stall_q && (count_q < DEPTH_C);
        // Flush discards any same-cycle accept and pop.
        accept = rdy_in && !flush && req && bus.cache_rdy;
        pop    = rdy_in && !flush && (count_q != '0) && bus.dec_rdy;

        stall_on_accept = (bus.inst_in[6:4] == 3'b110);
        accept_next_pc  = fetch_pc_q + ADDR_W'(4);
`ifdef IF_JAL_FOLLOW_EN
        jal_imm = {{(ADDR_W-21){bus.inst_in[31]}}, bus.inst_in[31], bus.inst_in[19:12],
                   bus.inst_in[20], bus.inst_in[30:21], 1'b0};
        if (bus.inst_in[6:0] == 7'b1101111) begin
            stall_on_accept = 1'b0;
            accept_next_pc  = fetch_pc_q + jal_imm;
        end
`endif
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if_stall_d = if_stall_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;

        if (rdy_in) begin
            if (flush) begin
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
                if_stall_d = 1'b0;
                fetch_pc_d = rob2if;
            end else begin
                if (accept) begin
                    pc_mem_d[tail_q]   = fetch_pc_q;
                    inst_mem_d[tail_q] = bus.inst_in;
                    tail_d             = tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                count_d = count_q + CNT_W'(accept) - CNT_W'(pop);

                // Redirects only apply to an already-registered stall; accept is
                // impossible while stalled, so these branches never collide.
                if (if_stall_q && alu2if_cont) begin
                    fetch_pc_d = alu2if;
                    if_stall_d = 1'b0;
                end else if (if_stall_q && decUpd) begin
                    fetch_pc_d = dec2if;
                    if_stall_d = 1'b0;
                end else if (accept) begin
                    fetch_pc_d = accept_next_pc;
                    if_stall_d = stall_on_accept;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            fetch_pc_q <= RESET_PC;
            if_stall_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pc_mem_q   <= '{default: '0};
            inst_mem_q <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if_stall_q <= if_stall_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

    always_comb begin
        bus.next_PC   = fetch_pc_q;
        bus.next_inst = req;
        bus.if2dec    = (count_q != '0);
        bus.iq_count  = count_q;
        bus.inst_out  = (count_q != '0) ? inst_mem_q[head_q] : '0;
        bus.pc_out    = (count_q != '0) ? pc_mem_q[head_q]   : '0;
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, JAL sequence, and randomized run
// against a queue-based reference model. Honours IF_JAL_FOLLOW_EN like the design.
module tb_ifetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] JAL20 = 32'h0200006F;

    logic        clk;
    logic        rst_in, rdy_in, flush, alu2if_cont, decUpd;
    logic [31:0] rob2if, alu2if, dec2if;

    ifetch_queue_if #(.ADDR_W(32), .INST_W(32), .IQ_DEPTH(DEPTH)) bus ();

    ifetch_queue #(.ADDR_W(32), .INST_W(32), .IQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus),
        .flush(flush), .rob2if(rob2if), .alu2if_cont(alu2if_cont), .alu2if(alu2if),
        .decUpd(decUpd), .dec2if(dec2if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit rst, rdy, crdy;  logic [31:0] inst;  bit drdy, fl;  logic [31:0] rob;
        bit ac;  logic [31:0] alu;  bit du;  logic [31:0] dec;
        logic [31:0] e_pc;  bit e_ni, e_v;  logic [31:0] e_inst, e_pco;  int e_cnt;
    } vec_t;

    function automatic vec_t mk(bit rst, bit rdy, bit crdy, logic [31:0] inst, bit drdy,
                                bit fl, logic [31:0] rob, bit ac, logic [31:0] alu,
                                bit du, logic [31:0] dec, logic [31:0] e_pc, bit e_ni,
                                bit e_v, logic [31:0] e_inst, logic [31:0] e_pco, int e_cnt);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.crdy = crdy; v.inst = inst; v.drdy = drdy;
        v.fl = fl; v.rob = rob; v.ac = ac; v.alu = alu; v.du = du; v.dec = dec;
        v.e_pc = e_pc; v.e_ni = e_ni; v.e_v = e_v; v.e_inst = e_inst;
        v.e_pco = e_pco; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_in = v.rst; rdy_in = v.rdy; bus.cache_rdy = v.crdy; bus.inst_in = v.inst;
        bus.dec_rdy = v.drdy; flush = v.fl; rob2if = v.rob; alu2if_cont = v.ac;
        alu2if = v.alu; decUpd = v.du; dec2if = v.dec;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        chk({tag, ".next_PC"},   bus.next_PC,   v.e_pc);
        chk({tag, ".next_inst"}, bus.next_inst, v.e_ni);
        chk({tag, ".if2dec"},    bus.if2dec,    v.e_v);
        chk({tag, ".inst_out"},  bus.inst_out,  v.e_inst);
        chk({tag, ".pc_out"},    bus.pc_out,    v.e_pco);
        chk({tag, ".iq_count"},  bus.iq_count,  v.e_cnt);
    endtask

    // Reference model: plain queue of (pc, inst) pairs plus fetch address and stall bit.
    logic [31:0] m_pc;
    bit          m_stall;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    function automatic logic [31:0] j_imm(input logic [31:0] w);
        int imm;
        imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
        if (w[31]) imm = imm - 1048576;
        return 32'(imm);
    endfunction

    task automatic model_step();
        bit req, acc, pop, follow;
        if (rst_in) begin
            m_pc = 32'h0; m_stall = 0; q_pc.delete(); q_inst.delete();
        end else if (rdy_in) begin
            req = !m_stall && (q_pc.size() < DEPTH);
            acc = req && bus.cache_rdy;
            pop = (q_pc.size() > 0) && bus.dec_rdy;
            if (flush) begin
                q_pc.delete(); q_inst.delete(); m_stall = 0; m_pc = rob2if;
            end else begin
                if (pop) begin
                    void'(q_pc.pop_front()); void'(q_inst.pop_front());
                end
                if (m_stall && alu2if_cont) begin
                    m_pc = alu2if; m_stall = 0;
                end else if (m_stall && decUpd) begin
                    m_pc = dec2if; m_stall = 0;
                end else if (acc) begin
                    q_pc.push_back(m_pc); q_inst.push_back(bus.inst_in);
`ifdef IF_JAL_FOLLOW_EN
                    follow = (bus.inst_in[6:0] == 7'b1101111);
`else
                    follow = 0;
`endif
                    if (follow) begin
                        m_pc = m_pc + j_imm(bus.inst_in);
                    end else begin
                        m_pc = m_pc + 32'd4;
                        m_stall = (bus.inst_in[6:4] == 3'b110);
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: w[6:0] = 7'b0010011;
            6: w[6:0] = 7'b1100011;
            7: w[6:0] = 7'b1100111;
            8: w[6:0] = 7'b1101111;
            default: ;
        endcase
        return w;
    endfunction

    vec_t tbl[$];
    vec_t jseq[$];

    initial begin
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // rst rdy crdy inst drdy fl rob ac alu du dec | pc ni v inst pco cnt
        tbl.push_back(mk(1,1,0,0,   0,0,0,     0,0,    0,0,     32'h0,  1,0,0,   32'h0, 0));
        tbl.push_back(mk(0,1,1,ADDI,1,0,0,     0,0,    0,0,     32'h4,  1,1,ADDI,32'h0, 1));
        tbl.push_back(mk(0,1,1,ADDI,1,0,0,     0,0,    0,0,     32'h8,  1,1,ADDI,32'h4, 1));
        tbl.push_back(mk(0,1,1,BEQ, 1,0,0,     1,32'h80,0,0,    32'hC,  0,1,BEQ, 32'h8, 1));
        tbl.push_back(mk(0,1,1,ADDI,0,0,0,     1,32'h40,0,0,    32'h40, 1,1,BEQ, 32'h8, 1));
        tbl.push_back(mk(0,1,1,ADDI,0,0,0,     0,0,    1,32'h200,32'h44,1,1,BEQ, 32'h8, 2));
        tbl.push_back(mk(0,1,1,ADDI,0,0,0,     0,0,    0,0,     32'h48, 1,1,BEQ, 32'h8, 3));
        tbl.push_back(mk(0,1,1,ADDI,0,0,0,     0,0,    0,0,     32'h4C, 0,1,BEQ, 32'h8, 4));
        tbl.push_back(mk(0,1,1,ADDI,0,0,0,     0,0,    0,0,     32'h4C, 0,1,BEQ, 32'h8, 4));
        tbl.push_back(mk(0,1,1,ADDI,1,0,0,     0,0,    0,0,     32'h4C, 1,1,ADDI,32'h40,3));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,0,1,ADDI,1,1,32'h100,0,0,0,0,   32'h4C, 1,1,ADDI,32'h40,3));
        tbl.push_back(mk(0,1,1,ADDI,1,1,32'h100,1,32'h40,0,0,  32'h100,1,0,0,   32'h0, 0));
        tbl.push_back(mk(0,1,1,ADDI,0,0,0,     0,0,    0,0,     32'h104,1,1,ADDI,32'h100,1));
        tbl.push_back(mk(1,1,1,ADDI,1,0,0,     0,0,    0,0,     32'h0,  1,0,0,   32'h0, 0));

        for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // JAL +0x20 at PC 4
        jseq.push_back(mk(1,1,0,0,    0,0,0,0,0,0,0,        32'h0, 1,0,0,    32'h0, 0));
        jseq.push_back(mk(0,1,1,ADDI, 1,0,0,0,0,0,0,        32'h4, 1,1,ADDI, 32'h0, 1));
`ifdef IF_JAL_FOLLOW_EN
        jseq.push_back(mk(0,1,1,JAL20,1,0,0,0,0,0,0,        32'h24,1,1,JAL20,32'h4, 1));
        jseq.push_back(mk(0,1,0,ADDI, 1,0,0,0,0,0,0,        32'h24,1,0,0,    32'h0, 0));
        jseq.push_back(mk(0,1,0,ADDI, 1,0,0,0,0,1,32'h80,   32'h24,1,0,0,    32'h0, 0));
`else
        jseq.push_back(mk(0,1,1,JAL20,1,0,0,0,0,0,0,        32'h8, 0,1,JAL20,32'h4, 1));
        jseq.push_back(mk(0,1,1,ADDI, 1,0,0,0,0,0,0,        32'h8, 0,0,0,    32'h0, 0));
        jseq.push_back(mk(0,1,0,ADDI, 1,0,0,0,0,1,32'h80,   32'h80,1,0,0,    32'h0, 0));
`endif
        for (int i = 0; i < jseq.size(); i++) run_vec($sformatf("jal%0d", i), jseq[i]);

        // Randomized run against the reference model.
        rst_in = 1; rdy_in = 1; flush = 0; alu2if_cont = 0; decUpd = 0;
        bus.cache_rdy = 0; bus.dec_rdy = 0;
        @(posedge clk); model_step(); #1;
        for (int c = 0; c < 3000; c++) begin
            rst_in        = ($urandom_range(0, 199) == 0);
            rdy_in        = ($urandom_range(0, 7) != 0);
            bus.cache_rdy = ($urandom_range(0, 3) != 0);
            bus.inst_in   = rand_inst();
            bus.dec_rdy   = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 39) == 0);
            rob2if        = {$urandom_range(0, 255), 2'b00};
            alu2if_cont   = ($urandom_range(0, 7) == 0);
            alu2if        = {$urandom_range(0, 255), 2'b00};
            decUpd        = ($urandom_range(0, 7) == 0);
            dec2if        = {$urandom_range(0, 255), 2'b00};
            @(posedge clk);
            model_step();
            #1;
            chk("rnd.next_PC",   bus.next_PC,   m_pc);
            chk("rnd.next_inst", bus.next_inst, !m_stall && (q_pc.size() < DEPTH));
            chk("rnd.if2dec",    bus.if2dec,    q_pc.size() > 0);
            chk("rnd.inst_out",  bus.inst_out,  (q_pc.size() > 0) ? q_inst[0] : 32'h0);
            chk("rnd.pc_out",    bus.pc_out,    (q_pc.size() > 0) ? q_pc[0] : 32'h0);
            chk("rnd.iq_count",  bus.iq_count,  q_pc.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
